prbs_seq_ctrl: RTL and testbench
================================

Name: prbs_seq_ctrl

Overview:
Sequencing controller for the I and Q PRBS9 generators in the transmitter.
- Drives the generators' synchronous reset (seed load) and their enable strobes.
- Issues one enable per symbol period of OS clocks, at a selectable phase.
- Tracks position within the 511-symbol PRBS9 sequence and counts completed sequence periods, so the downstream BER checker and filter stage can align.

Parameters:
OS, 4, oversampling factor in clocks per symbol; power of 2, minimum 2
NB_PHASE, $clog2(OS), width of phase select and phase counter
NB_PERIOD, 16, width of completed-period counter

Ports:
clock  input  1  system clock
i_reset  input  1  synchronous active-high reset
i_start  input  1  single-cycle pulse: (re)load seeds and start
i_stop  input  1  single-cycle pulse: stop and return to idle
i_pause  input  1  level: freeze the sequence while high
i_phase  input  NB_PHASE  oversample phase at which enables fire; sampled in LOAD
o_prbs_reset  output  1  drives i_reset of both PRBS9 generators
o_enable  output  1  drives i_enable of both PRBS9 generators
o_sym_cnt  output  9  symbol index within the sequence, 0..510
o_period_strb  output  1  one-cycle pulse when o_sym_cnt wraps 510->0
o_period_cnt  output  NB_PERIOD  completed 511-symbol periods, saturating
o_state  output  2  FSM state: IDLE=0, LOAD=1, RUN=2, PAUSE=3

Behaviour:
- Reset value of every output:
  - state IDLE; o_prbs_reset=1; o_enable=0; o_sym_cnt=0; o_period_strb=0; o_period_cnt=0.
  - Internal phase_cnt=0; phase_sel=0.
- IDLE:
  - o_prbs_reset=1 continuously, so the generators hold their seeds; o_enable=0.
  - i_start -> LOAD.
- LOAD (exactly 1 cycle):
  - o_prbs_reset=1.
  - phase_sel<=i_phase; phase_cnt<=0; o_sym_cnt<=0; o_period_cnt<=0.
  - Next state RUN, except i_stop -> IDLE.
- RUN:
  - o_prbs_reset=0.
  - phase_cnt increments each cycle, wrapping OS-1->0.
  - o_enable = (state==RUN) && (phase_cnt==phase_sel), decoded from registers only; no combinational path from inputs.
- Latency:
  - LOAD at cycle t; first o_enable at cycle t+1+phase_sel; subsequent enables every OS cycles.
- Symbol counting:
  - Each enable cycle: o_sym_cnt increments, wrapping 510->0.
  - On that wrap cycle (enable with o_sym_cnt==510), the next cycle has o_sym_cnt=0 and o_period_strb=1.
  - o_period_cnt increments in the same cycle, saturating at all-ones.
- PAUSE:
  - Entered from RUN when i_pause=1 (and no stop/start).
  - o_enable=0; phase_cnt, o_sym_cnt and o_period_cnt frozen; o_prbs_reset=0, so generator state is kept.
  - i_pause=0 -> RUN, resuming at the frozen phase_cnt with no lost or duplicated enable.
- Priority in any state: i_reset > i_stop > i_start > i_pause.
  - i_stop in RUN/PAUSE/LOAD -> IDLE; counters hold their values until the next LOAD.
  - i_start in RUN/PAUSE -> LOAD (restart from seed).
  - i_start and i_stop in the same cycle -> IDLE.
- i_pause in IDLE or LOAD is ignored; it is evaluated from RUN only.
- i_reset mid-operation: all outputs return to reset values in the next cycle; no enable is issued in that cycle.
- o_period_strb is never asserted outside RUN.

Decomposition:
- Package prbs_pkg:
  - state enum/localparams IDLE/LOAD/RUN/PAUSE;
  - PRBS9_LEN=511;
  - NB_SYM=9.
- One sub-module, prbs_sym_timer: phase counter plus symbol/period counters with clear, advance and freeze inputs.
- The FSM stays in prbs_seq_ctrl.

Test Plan:
1. Reset, then i_start at t with OS=4, i_phase=0 -> o_prbs_reset high through t, low at t+1; o_enable at t+1, t+5, t+9; o_state=2 from t+1.
2. OS=4, i_phase=3, run 511 enables -> first enable at t+4; after enable #511, the next cycle has o_sym_cnt=0, o_period_strb=1 for 1 cycle, o_period_cnt=1.
3. In RUN with o_sym_cnt=100 and phase_cnt=2, hold i_pause 10 cycles -> no enables, counts frozen at 100/2; on release, the next enable arrives at the same phase offset; o_sym_cnt continues 101.
4. i_stop and i_start asserted in the same RUN cycle -> o_state=0 next cycle, o_prbs_reset=1, no further enables.
5. i_start during RUN at o_sym_cnt=300 -> one LOAD cycle with o_prbs_reset=1, o_sym_cnt=0, o_period_cnt=0; enables restart per i_phase.
6. i_reset asserted mid-RUN and mid-PAUSE -> next cycle all outputs at reset values; force o_period_cnt near all-ones and run 2 periods -> it saturates at 16'hFFFF.

Source files
------------

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared types and constants for the PRBS9 sequencing controller
package prbs_pkg;

  localparam int PRBS9_LEN = 511;
  localparam int NB_SYM    = 9;

  localparam logic [NB_SYM-1:0] SYM_LAST = NB_SYM'(PRBS9_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_e;

endpackage

// File: rtl/prbs_sym_timer.sv
// rtl/prbs_sym_timer.sv - oversample phase counter plus symbol and period counters
// Clear beats freeze; while unfrozen the phase ticks every clock and symbols advance on i_advance.
module prbs_sym_timer
  import prbs_pkg::*;
#(
  parameter int OS        = 4,
  parameter int NB_PHASE  = $clog2(OS),
  parameter int NB_PERIOD = 16
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_freeze,
  input  logic                 i_advance,
  output logic [NB_PHASE-1:0]  o_phase_cnt,
  output logic [NB_SYM-1:0]    o_sym_cnt,
  output logic                 o_period_strb,
  output logic [NB_PERIOD-1:0] o_period_cnt
);

  localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OS - 1);

  logic [NB_PHASE-1:0]  phase_cnt_q, phase_cnt_d;
  logic [NB_SYM-1:0]    sym_cnt_q, sym_cnt_d;
  logic                 strb_q, strb_d;
  logic [NB_PERIOD-1:0] period_cnt_q, period_cnt_d;

  always_comb begin
    phase_cnt_d  = phase_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    strb_d       = strb_q;
    period_cnt_d = period_cnt_q;
    if (i_clear) begin
      phase_cnt_d  = '0;
      sym_cnt_d    = '0;
      strb_d       = 1'b0;
      period_cnt_d = '0;
    end else if (!i_freeze) begin
      phase_cnt_d = (phase_cnt_q == PHASE_LAST) ? '0 : phase_cnt_q + NB_PHASE'(1);
      strb_d      = 1'b0;
      if (i_advance) begin
        if (sym_cnt_q == SYM_LAST) begin
          sym_cnt_d = '0;
          strb_d    = 1'b1;
          if (period_cnt_q != '1) begin
            period_cnt_d = period_cnt_q + NB_PERIOD'(1);
          end
        end else begin
          sym_cnt_d = sym_cnt_q + NB_SYM'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase_cnt_q  <= '0;
      sym_cnt_q    <= '0;
      strb_q       <= 1'b0;
      period_cnt_q <= '0;
    end else begin
      phase_cnt_q  <= phase_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      strb_q       <= strb_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign o_phase_cnt   = phase_cnt_q;
  assign o_sym_cnt     = sym_cnt_q;
  assign o_period_strb = strb_q;
  assign o_period_cnt  = period_cnt_q;

endmodule

// File: rtl/prbs_seq_ctrl.sv
// rtl/prbs_seq_ctrl.sv - seed-load / enable sequencer for the I and Q PRBS9 generators
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int OS        = 4,
  parameter int NB_PHASE  = $clog2(OS),
  parameter int NB_PERIOD = 16
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_pause,
  input  logic [NB_PHASE-1:0]  i_phase,
  output logic                 o_prbs_reset,
  output logic                 o_enable,
  output logic [NB_SYM-1:0]    o_sym_cnt,
  output logic                 o_period_strb,
  output logic [NB_PERIOD-1:0] o_period_cnt,
  output logic [1:0]           o_state
);

  state_e              state_q, state_d;
  logic [NB_PHASE-1:0] phase_sel_q;
  logic [NB_PHASE-1:0] phase_cnt;
  logic                timer_clear;
  logic                timer_freeze;
  logic                timer_strb;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase_sel_q <= '0;
    end else if (state_q == LOAD) begin
      phase_sel_q <= i_phase;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!i_stop && i_start) state_d = LOAD;
      end
      LOAD: begin
        state_d = i_stop ? IDLE : RUN;
      end
      RUN: begin
        if (i_stop)       state_d = IDLE;
        else if (i_start) state_d = LOAD;
        else if (i_pause) state_d = PAUSE;
      end
      PAUSE: begin
        if (i_stop)        state_d = IDLE;
        else if (i_start)  state_d = LOAD;
        else if (!i_pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enable and strobe come from registers only, so no input can glitch them.
  always_comb begin
    o_prbs_reset  = 1'b0;
    o_enable      = 1'b0;
    o_period_strb = 1'b0;
    case (state_q)
      IDLE, LOAD: o_prbs_reset = 1'b1;
      RUN: begin
        o_enable      = (phase_cnt == phase_sel_q);
        o_period_strb = timer_strb;
      end
      default: ;
    endcase
  end

  // Clearing on entry as well as in LOAD makes the LOAD cycle itself show zeroed counts.
  assign timer_clear  = (state_q == LOAD) || (state_d == LOAD);
  assign timer_freeze = (state_q != RUN);
  assign o_state      = state_q;

  prbs_sym_timer #(
    .OS        (OS),
    .NB_PHASE  (NB_PHASE),
    .NB_PERIOD (NB_PERIOD)
  ) u_timer (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_clear       (timer_clear),
    .i_freeze      (timer_freeze),
    .i_advance     (o_enable),
    .o_phase_cnt   (phase_cnt),
    .o_sym_cnt     (o_sym_cnt),
    .o_period_strb (timer_strb),
    .o_period_cnt  (o_period_cnt)
  );

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// tb/tb_prbs_seq_ctrl.sv - directed vector bench for prbs_seq_ctrl
// A second instance (OS=2, 2-bit period counter) makes period-counter saturation reachable.
module tb_prbs_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset, start, stop, pause;
  logic [1:0] phase;

  logic        prbs_reset, enable, strb;
  logic [8:0]  sym;
  logic [15:0] pcnt;
  logic [1:0]  state;

  logic        prbs_reset2, enable2, strb2;
  logic [8:0]  sym2;
  logic [1:0]  pcnt2;
  logic [1:0]  state2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  prbs_seq_ctrl #(.OS(4), .NB_PERIOD(16)) dut (
    .clock         (clock),
    .i_reset       (reset),
    .i_start       (start),
    .i_stop        (stop),
    .i_pause       (pause),
    .i_phase       (phase),
    .o_prbs_reset  (prbs_reset),
    .o_enable      (enable),
    .o_sym_cnt     (sym),
    .o_period_strb (strb),
    .o_period_cnt  (pcnt),
    .o_state       (state)
  );

  prbs_seq_ctrl #(.OS(2), .NB_PERIOD(2)) dut2 (
    .clock         (clock),
    .i_reset       (reset),
    .i_start       (start),
    .i_stop        (stop),
    .i_pause       (pause),
    .i_phase       (phase[0]),
    .o_prbs_reset  (prbs_reset2),
    .o_enable      (enable2),
    .o_sym_cnt     (sym2),
    .o_period_strb (strb2),
    .o_period_cnt  (pcnt2),
    .o_state       (state2)
  );

  typedef struct {
    logic        st, sp, pa;
    logic [1:0]  ph;
    logic [1:0]  e_state;
    logic        e_pr, e_en;
    logic [8:0]  e_sym;
    logic        e_strb;
    logic [15:0] e_pcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int st, int sp, int pa, int ph, int es, int pr, int en,
                              int sy, int sb, int pc);
    vec_t v;
    v.st = 1'(st);  v.sp = 1'(sp);  v.pa = 1'(pa);  v.ph = 2'(ph);
    v.e_state = 2'(es);  v.e_pr = 1'(pr);  v.e_en = 1'(en);
    v.e_sym = 9'(sy);  v.e_strb = 1'(sb);  v.e_pcnt = 16'(pc);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int es, input int pr, input int en,
                           input int sy, input int sb, input int pc);
    check({name, ".state"}, 32'(state), 32'(es));
    check({name, ".prbs_reset"}, 32'(prbs_reset), 32'(pr));
    check({name, ".enable"}, 32'(enable), 32'(en));
    check({name, ".sym_cnt"}, 32'(sym), 32'(sy));
    check({name, ".period_strb"}, 32'(strb), 32'(sb));
    check({name, ".period_cnt"}, 32'(pcnt), 32'(pc));
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 unit after the rising edge.
  task automatic step(input logic st, input logic sp, input logic pa, input logic [1:0] ph,
                      input logic rst);
    @(negedge clock);
    start = st; stop = sp; pause = pa; phase = ph; reset = rst;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int k;
    int n;

    // st sp pa ph | state pr en sym strb pcnt
    tbl.push_back(mk(1,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,0, 2,0,1,2,0,0));
    tbl.push_back(mk(1,1,0,0, 0,1,0,3,0,0));
    tbl.push_back(mk(0,0,1,0, 0,1,0,3,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1,0,3,0,0));
    tbl.push_back(mk(1,0,0,2, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,1,1,0,0));
    tbl.push_back(mk(0,0,1,2, 3,0,0,2,0,0));
    tbl.push_back(mk(0,0,1,2, 3,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,2, 2,0,1,2,0,0));
    tbl.push_back(mk(0,1,0,2, 0,1,0,3,0,0));
    tbl.push_back(mk(1,0,0,1, 1,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,1, 0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 0,1,0,0,0,0));

    start = 0; stop = 0; pause = 0; phase = 0; reset = 1;
    step(0,0,0,0,1);
    step(0,0,0,0,1);
    check_all("reset", 0,1,0,0,0,0);
    step(0,0,0,0,0);
    check_all("idle_after_reset", 0,1,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].ph, 1'b0);
      check_all($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_pr, tbl[i].e_en,
                tbl[i].e_sym, tbl[i].e_strb, tbl[i].e_pcnt);
    end

    // Full 511-symbol period at phase 3: enables on LOAD+4, +8, ...
    step(1,0,0,3,0);
    check("p3_load_state", 32'(state), 1);
    bad = 0;
    for (int c = 1; c <= 2044; c++) begin
      step(0,0,0,3,0);
      if (enable !== ((c % 4) == 0) || strb !== 1'b0 || state !== 2'd2) bad++;
      if (c == 2044) check("sym_at_enable_511", 32'(sym), 510);
    end
    check("enable_cadence_511", 32'(bad), 0);
    step(0,0,0,3,0);
    check_all("wrap", 2,0,0,0,1,1);
    step(0,0,0,3,0);
    check_all("after_wrap", 2,0,0,0,0,1);

    // Reset while running, with start also asserted.
    for (int c = 0; c < 10; c++) step(0,0,0,3,0);
    step(1,0,0,3,1);
    check_all("reset_mid_run", 0,1,0,0,0,0);
    step(0,0,0,0,0);

    // Reset while paused.
    step(1,0,0,0,0);
    for (int c = 0; c < 6; c++) step(0,0,0,0,0);
    step(0,0,1,0,0);
    check("pause_before_reset", 32'(state), 3);
    step(0,0,1,0,1);
    check_all("reset_mid_pause", 0,1,0,0,0,0);
    step(0,0,0,0,0);

    // Pause at sym 100 / phase 2, phase_sel 0.
    step(1,0,0,0,0);
    for (int c = 1; c <= 398; c++) step(0,0,0,0,0);
    check("sym_before_pause", 32'(sym), 100);
    bad = 0;
    for (int c = 399; c <= 408; c++) begin
      step(0,0,1,0,0);
      if (state !== 2'd3 || enable !== 1'b0 || sym !== 9'd100) bad++;
    end
    check("pause_frozen", 32'(bad), 0);
    step(0,0,0,0,0);
    check("resume_c409_en", 32'(enable), 0);
    check("resume_c409_state", 32'(state), 2);
    step(0,0,0,0,0);
    check("resume_c410_en", 32'(enable), 0);
    step(0,0,0,0,0);
    check("resume_c411_en", 32'(enable), 1);
    check("resume_c411_sym", 32'(sym), 100);
    step(0,0,0,0,0);
    check("resume_c412_sym", 32'(sym), 101);

    // Restart from RUN at sym 300.
    k = 0;
    while (sym !== 9'd300 && k < 3000) begin
      step(0,0,0,0,0);
      k++;
    end
    check("reach_sym300", 32'(sym), 300);
    step(1,0,0,1,0);
    check_all("restart_load", 1,1,0,0,0,0);
    step(0,0,0,1,0);
    check_all("restart_pc0", 2,0,0,0,0,0);
    step(0,0,0,1,0);
    check_all("restart_pc1", 2,0,1,0,0,0);
    step(0,0,1,1,0);
    check("pause_again", 32'(state), 3);
    step(1,0,1,1,0);
    check("start_beats_pause", 32'(state), 1);

    // Saturation on the 2-bit period counter of dut2.
    step(0,0,0,0,1);
    step(0,0,0,0,0);
    step(1,0,0,0,0);
    n = 0;
    k = 0;
    while (n < 4 && k < 6000) begin
      step(0,0,0,0,0);
      k++;
      if (strb2 === 1'b1) begin
        n++;
        check($sformatf("sat_pcnt_%0d", n), 32'(pcnt2), (n > 3) ? 3 : n);
        check($sformatf("sat_sym_%0d", n), 32'(sym2), 0);
      end
    end
    check("sat_periods_seen", 32'(n), 4);
    step(0,0,0,0,0);
    check("sat_hold", 32'(pcnt2), 3);
    check("sat_strb_low", 32'(strb2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
